// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers of the post-ID
// pipeline stages and resolves the ID instruction's source operands. It picks
// forwarded stage data or regfile data, and it raises stall when a needed
// result is not yet available.
//
// Build option: define HAZARD_SCOREBOARD_FORWARD_EN to enable forwarding.
// When it is not defined, the block is a pure interlock. Any match stalls,
// operands always come from the regfile, and stage_result is ignored.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   issue_valid/rd/we/is_load
//                         ID instruction advancing into stage 0
//   rs1, rs2, rs1_used, rs2_used
//                         source registers of the ID instruction
//   flush                 kill the stage-0 entry and suppress issue
//   stage_result          per-stage results, stage i in [i*XLEN +: XLEN]
//   regfile_rs1/2_data    regfile read data
//   rs1/2_data, rs1/2_fwd resolved operands (combinational)
//   stall                 hold IF/ID and insert a bubble (combinational)
//   stall_count           saturating count of stall cycles
module hazard_scoreboard #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned REG_ADDR_W       = 4,
    parameter int unsigned NUM_STAGES       = 4,
    parameter int unsigned LOAD_READY_STAGE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [REG_ADDR_W-1:0]      issue_rd,
    input  logic                       issue_we,
    input  logic                       issue_is_load,
    input  logic [REG_ADDR_W-1:0]      rs1,
    input  logic [REG_ADDR_W-1:0]      rs2,
    input  logic                       rs1_used,
    input  logic                       rs2_used,
    input  logic                       flush,
    input  logic [NUM_STAGES*XLEN-1:0] stage_result,
    input  logic [XLEN-1:0]            regfile_rs1_data,
    input  logic [XLEN-1:0]            regfile_rs2_data,
    output logic [XLEN-1:0]            rs1_data,
    output logic [XLEN-1:0]            rs2_data,
    output logic                       rs1_fwd,
    output logic                       rs2_fwd,
    output logic                       stall,
    output logic [31:0]                stall_count
);

    localparam int unsigned CNT_W = 32;

    logic [NUM_STAGES-1:0] ent_valid;
    logic [NUM_STAGES-1:0] ent_we;
    logic [REG_ADDR_W-1:0] ent_rd [NUM_STAGES];
    logic [NUM_STAGES-1:0] match1;
    logic [NUM_STAGES-1:0] match2;
    logic                  issue_fire;

    // A stalled or flushed issue becomes a bubble in stage 0.
    assign issue_fire = issue_valid & ~stall & ~flush;

    // Entry valid bits and the stall counter; these are the only reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid   <= '0;
            stall_count <= '0;
        end else begin
            ent_valid <= {ent_valid[NUM_STAGES-2:0], issue_fire};
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    // Entry payload shifts every cycle; it is qualified by ent_valid.
    always_ff @(posedge clk) begin
        ent_we    <= {ent_we[NUM_STAGES-2:0], issue_we};
        ent_rd[0] <= issue_rd;
        for (int i = 1; i < NUM_STAGES; i++) begin
            ent_rd[i] <= ent_rd[i-1];
        end
    end

    // Per-entry source match. x0 never matches.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            match1[i] = ent_valid[i] & ent_we[i] & (ent_rd[i] != '0)
                        & (ent_rd[i] == rs1) & rs1_used;
            match2[i] = ent_valid[i] & ent_we[i] & (ent_rd[i] != '0)
                        & (ent_rd[i] == rs2) & rs2_used;
        end
    end

`ifdef HAZARD_SCOREBOARD_FORWARD_EN

    localparam int unsigned IDX_W = $clog2(NUM_STAGES);

    logic [NUM_STAGES-1:0] ent_load;
    logic [NUM_STAGES-1:0] ready;
    logic [XLEN-1:0]       result [NUM_STAGES];
    logic                  hit1;
    logic                  hit2;
    logic                  rdy1;
    logic                  rdy2;
    logic [IDX_W-1:0]      sel1;
    logic [IDX_W-1:0]      sel2;

    always_ff @(posedge clk) begin
        ent_load <= {ent_load[NUM_STAGES-2:0], issue_is_load};
    end

    // A load result exists only from LOAD_READY_STAGE onward.
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            ready[i]  = ~ent_load[i] | (i >= int'(LOAD_READY_STAGE));
            result[i] = stage_result[i*XLEN +: XLEN];
        end
    end

    // Youngest (lowest-index) match wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (match1[i] && !hit1) begin
                hit1 = 1'b1;
                rdy1 = ready[i];
                sel1 = IDX_W'(i);
            end
            if (match2[i] && !hit2) begin
                hit2 = 1'b1;
                rdy2 = ready[i];
                sel2 = IDX_W'(i);
            end
        end
    end

    always_comb begin
        rs1_fwd  = hit1 & rdy1;
        rs2_fwd  = hit2 & rdy2;
        rs1_data = rs1_fwd ? result[sel1] : regfile_rs1_data;
        rs2_data = rs2_fwd ? result[sel2] : regfile_rs2_data;
        stall    = (hit1 & ~rdy1) | (hit2 & ~rdy2);
    end

`else

    // Interlock-only build: every match is treated as not ready.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{stage_result, issue_is_load};

    always_comb begin
        rs1_fwd  = 1'b0;
        rs2_fwd  = 1'b0;
        rs1_data = regfile_rs1_data;
        rs2_data = regfile_rs2_data;
        stall    = (|match1) | (|match2);
    end

`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 4, giving the register address width (RV32E).
REQ-003 The block SHALL have parameter NUM_STAGES, default 4, giving the number of tracked post-ID stages (EX, MEMPREP, MEMEX, WB); legal range 2..8.
REQ-004 The block SHALL have parameter LOAD_READY_STAGE, default 3, giving the first stage index whose load result is valid; legal range 1..NUM_STAGES-1.
REQ-005 Ports SHALL be (name, direction, width, meaning):
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous, active-high reset
 issue_valid  in  1  ID instruction advances into stage 0 this cycle
 issue_rd  in  REG_ADDR_W  destination of issuing instruction
 issue_we  in  1  issuing instruction writes rd
 issue_is_load  in  1  issuing instruction is a load
 rs1, rs2  in  REG_ADDR_W  source registers of the ID instruction
 rs1_used, rs2_used  in  1  source is actually read
 flush  in  1  kill the stage-0 entry and suppress issue
 stage_result  in  NUM_STAGES*XLEN  result of stage i in bits [i*XLEN +: XLEN]
 regfile_rs1_data, regfile_rs2_data  in  XLEN  regfile read data
 rs1_data, rs2_data  out  XLEN  resolved operand data
 rs1_fwd, rs2_fwd  out  1  operand was taken from a pipeline stage
 stall  out  1  hold IF/ID; insert bubble into stage 0
 stall_count  out  32  saturating count of stall cycles

Function
REQ-006 The block SHALL hold NUM_STAGES entries {valid, we, rd, is_load}; on each rising edge entry i SHALL move to entry i+1, and entry NUM_STAGES-1 SHALL retire.
REQ-007 Entry 0 SHALL load {1, issue_we, issue_rd, issue_is_load} when issue_valid=1, stall=0 and flush=0; otherwise it SHALL load valid=0 (bubble).
REQ-008 An entry SHALL match source rsN when valid=1, we=1, rd==rsN, rd!=0, and rsN_used=1.
REQ-009 An entry at index i SHALL be ready when is_load=0 or i>=LOAD_READY_STAGE.
REQ-010 For each source, only the matching entry with the lowest index (youngest) SHALL be considered.
REQ-011 If the youngest match is ready, rsN_data SHALL equal stage_result slice i and rsN_fwd SHALL be 1 in the same cycle (combinational).
REQ-012 If there is no match, rsN_data SHALL equal regfile_rsN_data and rsN_fwd SHALL be 0.
REQ-013 stall SHALL be 1 when either source's youngest match is not ready; it SHALL be combinational from the current entries and the rs inputs.
REQ-014 Register 0 SHALL never cause forwarding or a stall.
REQ-015 Simultaneous issue_valid and stall SHALL produce a bubble; the ID instruction is reissued on a later cycle.
REQ-016 Simultaneous flush and stall SHALL produce a bubble; entries 1..NUM_STAGES-1 SHALL shift unaffected by flush.
REQ-017 stall_count SHALL increment by 1 on each rising edge where stall=1 and SHALL saturate at 0xFFFFFFFF.

Reset
REQ-018 While rst=1 at a rising edge, all entry valid bits SHALL clear and stall_count SHALL become 0.
REQ-019 After reset the block SHALL drive stall=0, rs1_fwd=rs2_fwd=0, and rsN_data=regfile_rsN_data.
REQ-020 A reset asserted mid-stall SHALL discard all in-flight entries with no retained state.

Configuration
REQ-021 With macro HAZARD_SCOREBOARD_FORWARD_EN defined, the block SHALL forward per REQ-011.
REQ-022 With HAZARD_SCOREBOARD_FORWARD_EN undefined, the block SHALL:
 - treat every match as not ready (pure interlock), so stall=1 on any match;
 - drive rsN_fwd=0 and rsN_data=regfile_rsN_data;
 - leave stage_result unused.

Verification
REQ-023 Back-to-back ALU dependency (FORWARD_EN): issue rd=5 (non-load), next cycle rs1=5 with stage_result[0]=0x1234 -> stall=0, rs1_fwd=1, rs1_data=0x1234.
REQ-024 Load-use (FORWARD_EN, defaults): issue load rd=3, then rs2=3 -> stall=1 for exactly 3 cycles, then rs2_data=stage_result[3], stall_count=3.
REQ-025 Youngest-wins: rd=7 in entries 0 and 2 with stage_result[0]=0xA and stage_result[2]=0xB -> rs1_data=0xA.
REQ-026 x0 and flush: issue rd=0 then rs1=0 -> no stall, no forward; issue rd=4 with flush=1, then rs1=4 -> no match, regfile data used.
REQ-027 Interlock build (FORWARD_EN undefined): issue rd=6, then rs1=6 -> stall=1 for 4 cycles until retirement; reset in cycle 2 -> stall=0 next cycle and stall_count=0.
REQ-028 Saturation: force stall_count to 0xFFFFFFFE, hold stall=1 for 3 cycles -> stall_count=0xFFFFFFFF.
